// File: rtl/bf16_mul_arbiter.sv
// bf16_mul_arbiter
// Shares a single bf16 multiplier between NUM_REQ requesters.
// - Round-robin grant into an operand register (S1).
// - The multiplier is purely combinational on S1.
// - Results land in an output register (S2), tagged with the requester index.
// Optional build macro BF16_MUL_ARB_STATS_EN adds saturating NaN/Inf result counters.
module bf16_mul_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DATA_WIDTH = 16,
   parameter int FLAG_WIDTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_b,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic                          o_res_valid,
   output logic [DATA_WIDTH-1:0]         o_res_data,
   output logic [FLAG_WIDTH-1:0]         o_res_flag,
   output logic [ID_WIDTH-1:0]           o_res_id,
   input  logic                          i_res_ready
`ifdef BF16_MUL_ARB_STATS_EN
   ,
   output logic [15:0]                   o_nan_cnt,
   output logic [15:0]                   o_inf_cnt
`endif
);

   localparam logic [FLAG_WIDTH-1:0] FLAG_NAN  = 4'b1000;
   localparam logic [FLAG_WIDTH-1:0] FLAG_ZERO = 4'b0100;
   localparam logic [FLAG_WIDTH-1:0] FLAG_INF  = 4'b0010;
   localparam logic [FLAG_WIDTH-1:0] FLAG_NORM = 4'b0001;

   logic                  s1Valid_q, s1Valid_d;
   logic [DATA_WIDTH-1:0] s1A_q, s1A_d;
   logic [DATA_WIDTH-1:0] s1B_q, s1B_d;
   logic [ID_WIDTH-1:0]   s1Id_q, s1Id_d;
   logic [ID_WIDTH-1:0]   rrPtr_q, rrPtr_d;
   logic                  resValid_q, resValid_d;
   logic [DATA_WIDTH-1:0] resData_q, resData_d;
   logic [FLAG_WIDTH-1:0] resFlag_q, resFlag_d;
   logic [ID_WIDTH-1:0]   resId_q, resId_d;

   logic                  s2Load;
   logic                  s1Free;
   logic                  grantFound;
   logic [ID_WIDTH-1:0]   grantId;
   logic [ID_WIDTH:0]     scanIdx;
   logic                  accept;
   logic [DATA_WIDTH-1:0] opA, opB;

   logic [DATA_WIDTH-1:0] mulData;
   logic [FLAG_WIDTH-1:0] mulFlag;
   logic                  signP;
   logic [7:0]            expA, expB;
   logic                  nanA, nanB, infA, infB, zeroA, zeroB;
   logic [8:0]            sigTop;
   logic signed [10:0]    expBiased;
   logic [6:0]            mantP;

   // Output stage may load when empty or being drained; S1 is free when empty or moving on.
   assign s2Load = ~resValid_q | i_res_ready;
   assign s1Free = ~s1Valid_q | s2Load;
   assign accept = s1Free & grantFound;

   // Round-robin scan starting at rrPtr_q, wrapping modulo NUM_REQ, first valid wins.
   always_comb begin
      grantFound = 1'b0;
      grantId    = '0;
      scanIdx    = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         scanIdx = {1'b0, rrPtr_q} + (ID_WIDTH+1)'(off);
         if (scanIdx >= (ID_WIDTH+1)'(NUM_REQ)) begin
            scanIdx = scanIdx - (ID_WIDTH+1)'(NUM_REQ);
         end
         if (!grantFound && i_req_valid[scanIdx[ID_WIDTH-1:0]]) begin
            grantFound = 1'b1;
            grantId    = scanIdx[ID_WIDTH-1:0];
         end
      end
   end

   assign o_req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grantId) : '0;
   assign opA         = i_req_a[grantId*DATA_WIDTH +: DATA_WIDTH];
   assign opB         = i_req_b[grantId*DATA_WIDTH +: DATA_WIDTH];

   // Combinational bf16 multiply on the S1 operands: specials first, then truncated normal product.
   always_comb begin
      mulData   = '0;
      mulFlag   = FLAG_NORM;
      signP     = s1A_q[15] ^ s1B_q[15];
      expA      = s1A_q[14:7];
      expB      = s1B_q[14:7];
      nanA      = (expA == 8'hFF) && (s1A_q[6:0] != 7'd0);
      nanB      = (expB == 8'hFF) && (s1B_q[6:0] != 7'd0);
      infA      = (expA == 8'hFF) && (s1A_q[6:0] == 7'd0);
      infB      = (expB == 8'hFF) && (s1B_q[6:0] == 7'd0);
      zeroA     = (expA == 8'h00);
      zeroB     = (expB == 8'h00);
      sigTop    = 9'((16'({1'b1, s1A_q[6:0]}) * 16'({1'b1, s1B_q[6:0]})) >> 7);
      expBiased = $signed({3'b000, expA}) + $signed({3'b000, expB}) - 11'sd127
                  + $signed({10'd0, sigTop[8]});
      mantP     = sigTop[8] ? sigTop[7:1] : sigTop[6:0];
      if (nanA || nanB) begin
         mulData = 16'h7FC0;
         mulFlag = FLAG_NAN;
      end else if ((zeroA && infB) || (infA && zeroB)) begin
         mulData = 16'hFFC0;
         mulFlag = FLAG_NAN;
      end else if (zeroA || zeroB) begin
         mulData = {signP, 15'd0};
         mulFlag = FLAG_ZERO;
      end else if (infA || infB) begin
         mulData = {signP, 15'h7F80};
         mulFlag = FLAG_INF;
      end else if (expBiased < 11'sd1) begin
         mulData = {signP, 15'd0};
         mulFlag = FLAG_ZERO;
      end else if (expBiased > 11'sd254) begin
         mulData = {signP, 15'h7F80};
         mulFlag = FLAG_INF;
      end else begin
         mulData = {signP, expBiased[7:0], mantP};
         mulFlag = FLAG_NORM;
      end
   end

   // Next-state for both pipeline stages and the round-robin pointer.
   always_comb begin
      s1Valid_d  = s1Valid_q;
      s1A_d      = s1A_q;
      s1B_d      = s1B_q;
      s1Id_d     = s1Id_q;
      rrPtr_d    = rrPtr_q;
      resValid_d = resValid_q;
      resData_d  = resData_q;
      resFlag_d  = resFlag_q;
      resId_d    = resId_q;
      if (s2Load) begin
         resValid_d = s1Valid_q;
         if (s1Valid_q) begin
            resData_d = mulData;
            resFlag_d = mulFlag;
            resId_d   = s1Id_q;
         end
      end
      if (s1Free) begin
         s1Valid_d = accept;
         if (accept) begin
            s1A_d   = opA;
            s1B_d   = opB;
            s1Id_d  = grantId;
            rrPtr_d = (grantId == ID_WIDTH'(NUM_REQ-1)) ? '0 : grantId + 1'b1;
         end
      end
   end

   // State registers; reset drops anything in flight and restarts arbitration at requester 0.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1Valid_q  <= 1'b0;
         s1A_q      <= '0;
         s1B_q      <= '0;
         s1Id_q     <= '0;
         rrPtr_q    <= '0;
         resValid_q <= 1'b0;
         resData_q  <= '0;
         resFlag_q  <= '0;
         resId_q    <= '0;
      end else begin
         s1Valid_q  <= s1Valid_d;
         s1A_q      <= s1A_d;
         s1B_q      <= s1B_d;
         s1Id_q     <= s1Id_d;
         rrPtr_q    <= rrPtr_d;
         resValid_q <= resValid_d;
         resData_q  <= resData_d;
         resFlag_q  <= resFlag_d;
         resId_q    <= resId_d;
      end
   end

   assign o_res_valid = resValid_q;
   assign o_res_data  = resData_q;
   assign o_res_flag  = resFlag_q;
   assign o_res_id    = resId_q;

`ifdef BF16_MUL_ARB_STATS_EN
   logic [15:0] nanCnt_q, nanCnt_d;
   logic [15:0] infCnt_q, infCnt_d;
   logic        resTaken;

   assign resTaken = resValid_q & i_res_ready;

   // Count NaN/Inf results as they are handed downstream, sticking at all-ones.
   always_comb begin
      nanCnt_d = nanCnt_q;
      infCnt_d = infCnt_q;
      if (resTaken && resFlag_q[3] && (nanCnt_q != 16'hFFFF)) begin
         nanCnt_d = nanCnt_q + 16'd1;
      end
      if (resTaken && resFlag_q[1] && (infCnt_q != 16'hFFFF)) begin
         infCnt_d = infCnt_q + 16'd1;
      end
   end

   // Statistics registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         nanCnt_q <= '0;
         infCnt_q <= '0;
      end else begin
         nanCnt_q <= nanCnt_d;
         infCnt_q <= infCnt_d;
      end
   end

   assign o_nan_cnt = nanCnt_q;
   assign o_inf_cnt = infCnt_q;
`endif

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Testbench for bf16_mul_arbiter: directed corner products plus randomized traffic
// checked against a behavioural model of arbitration, the two-slot pipeline and bf16 math.
module tb_bf16_mul_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  reqValid;
   logic [63:0] reqA;
   logic [63:0] reqB;
   logic [3:0]  reqReady;
   logic        resValid;
   logic [15:0] resData;
   logic [3:0]  resFlag;
   logic [1:0]  resId;
   logic        resReady;
`ifdef BF16_MUL_ARB_STATS_EN
   logic [15:0] nanCnt;
   logic [15:0] infCnt;
`endif

   int checks   = 0;
   int failures = 0;

   bf16_mul_arbiter dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (reqValid),
      .i_req_a     (reqA),
      .i_req_b     (reqB),
      .o_req_ready (reqReady),
      .o_res_valid (resValid),
      .o_res_data  (resData),
      .o_res_flag  (resFlag),
      .o_res_id    (resId),
      .i_res_ready (resReady)
`ifdef BF16_MUL_ARB_STATS_EN
      ,
      .o_nan_cnt   (nanCnt),
      .o_inf_cnt   (infCnt)
`endif
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: operand slot, result slot, next requester to favour.
   bit          mS1Valid = 0;
   bit          mS2Valid = 0;
   logic [21:0] mS1Item  = '0;
   logic [21:0] mS2Item  = '0;
   int          mRr      = 0;
   int          mNan     = 0;
   int          mInf     = 0;

   function automatic real pow2(int e);
      real r = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
      else        for (int i = 0; i < -e; i++) r = r / 2.0;
      return r;
   endfunction

   // Reference bf16 product computed from real-valued magnitudes; returns {flag, data}.
   function automatic logic [19:0] refMul(logic [15:0] a, logic [15:0] b);
      bit   s = a[15] ^ b[15];
      int   ea = int'(a[14:7]);
      int   eb = int'(b[14:7]);
      int   ma = int'(a[6:0]);
      int   mb = int'(b[6:0]);
      bit   nanA = (ea == 255) && (ma != 0);
      bit   nanB = (eb == 255) && (mb != 0);
      bit   infA = (ea == 255) && (ma == 0);
      bit   infB = (eb == 255) && (mb == 0);
      bit   zA = (ea == 0);
      bit   zB = (eb == 0);
      real  p;
      int   e;
      int   m;
      logic [7:0] eBits;
      logic [6:0] mBits;
      if (nanA || nanB) return {4'b1000, 16'h7FC0};
      if ((zA && infB) || (infA && zB)) return {4'b1000, 16'hFFC0};
      if (zA || zB) return {4'b0100, s, 15'd0};
      if (infA || infB) return {4'b0010, s, 15'h7F80};
      p = (1.0 + ma / 128.0) * pow2(ea - 127) * (1.0 + mb / 128.0) * pow2(eb - 127);
      e = 0;
      while (p >= 2.0) begin p = p / 2.0; e++; end
      while (p < 1.0)  begin p = p * 2.0; e--; end
      if (e < -126) return {4'b0100, s, 15'd0};
      if (e > 127)  return {4'b0010, s, 15'h7F80};
      m = $rtoi((p - 1.0) * 128.0);
      eBits = 8'(e + 127);
      mBits = 7'(m);
      return {4'b0001, s, eBits, mBits};
   endfunction

   // Grant the model expects for the current inputs.
   function automatic logic [3:0] expReady();
      logic [3:0] g = '0;
      bit found = 0;
      if (!mS1Valid || !mS2Valid || resReady) begin
         for (int k = 0; k < 4; k++) begin
            int n = (mRr + k) % 4;
            if (!found && reqValid[n]) begin
               g[n] = 1'b1;
               found = 1;
            end
         end
      end
      return g;
   endfunction

   // Advance one clock edge, updating the model from the inputs driven this cycle.
   task automatic tick();
      logic [3:0] g = expReady();
      bit s2Load = !mS2Valid || resReady;
      bit s1Free = !mS1Valid || s2Load;
      int gid = 0;
      for (int k = 0; k < 4; k++) if (g[k]) gid = k;
      @(posedge clk);
      if (rst) begin
         mS1Valid = 0; mS2Valid = 0; mS1Item = '0; mS2Item = '0;
         mRr = 0; mNan = 0; mInf = 0;
      end else begin
         if (mS2Valid && resReady) begin
            if (mS2Item[19] && mNan < 65535) mNan++;
            if (mS2Item[17] && mInf < 65535) mInf++;
         end
         if (s2Load) begin
            mS2Valid = mS1Valid;
            if (mS1Valid) mS2Item = mS1Item;
         end
         if (s1Free) begin
            mS1Valid = (g != 4'd0);
            if (g != 4'd0) begin
               mS1Item = {2'(gid), refMul(reqA[gid*16 +: 16], reqB[gid*16 +: 16])};
               mRr = (gid + 1) % 4;
            end
         end
      end
      #1;
   endtask

   function automatic logic [15:0] randOp();
      logic [15:0] specials [8] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80,
                                    16'h7FC1, 16'h0001, 16'h7F00, 16'h0080};
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 7)];
      return 16'($urandom);
   endfunction

   task automatic applyStimulus(logic [3:0] v, bit rdy);
      reqValid = v;
      resReady = rdy;
      for (int n = 0; n < 4; n++) begin
         reqA[n*16 +: 16] = randOp();
         reqB[n*16 +: 16] = randOp();
      end
   endtask

   // Reset state of the result port.
   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(4'b0000, 1'b1);
      tick();
      rst = 1'b0;
      #3;
      checks++; if (resValid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", resValid); end
      checks++; if (resData !== 16'h0)  begin failures++; $display("FAIL reset_data got=%h exp=0000", resData); end
      checks++; if (resFlag !== 4'h0)   begin failures++; $display("FAIL reset_flag got=%b exp=0000", resFlag); end
      checks++; if (resId !== 2'd0)     begin failures++; $display("FAIL reset_id got=%0d exp=0", resId); end
      checks++; if (reqReady !== 4'd0)  begin failures++; $display("FAIL reset_ready got=%b exp=0000", reqReady); end
   endtask

   // Single-pair corner products with fixed expected results, two cycles after acceptance.
   task automatic test_directed();
      int          req  [10] = '{0, 1, 2, 2, 2, 2, 3, 1, 1, 0};
      logic [15:0] va   [10] = '{16'h3F80, 16'h7F80, 16'h7F00, 16'h0080, 16'hFF00,
                                 16'h8080, 16'h7FC1, 16'h0001, 16'h8001, 16'h3F81};
      logic [15:0] vb   [10] = '{16'h4000, 16'h0000, 16'h7F00, 16'h0080, 16'h7F00,
                                 16'h0080, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F81};
      logic [15:0] xd   [10] = '{16'h4000, 16'hFFC0, 16'h7F80, 16'h0000, 16'hFF80,
                                 16'h8000, 16'h7FC0, 16'h0000, 16'h8000, 16'h3F82};
      logic [3:0]  xf   [10] = '{4'b0001, 4'b1000, 4'b0010, 4'b0100, 4'b0010,
                                 4'b0100, 4'b1000, 4'b0100, 4'b0100, 4'b0001};
      for (int i = 0; i < 10; i++) begin
         applyStimulus(4'b0001 << req[i], 1'b1);
         reqA[req[i]*16 +: 16] = va[i];
         reqB[req[i]*16 +: 16] = vb[i];
         #3;
         checks++;
         if (reqReady !== (4'b0001 << req[i])) begin
            failures++; $display("FAIL dir_grant[%0d] got=%b exp=%b", i, reqReady, 4'b0001 << req[i]);
         end
         tick();
         applyStimulus(4'b0000, 1'b1);
         #3;
         tick();
         #3;
         checks++;
         if ({resValid, resData, resFlag, resId} !== {1'b1, xd[i], xf[i], 2'(req[i])}) begin
            failures++;
            $display("FAIL dir_result[%0d] got v=%b d=%h f=%b id=%0d exp v=1 d=%h f=%b id=%0d",
                     i, resValid, resData, resFlag, resId, xd[i], xf[i], req[i]);
         end
         tick();
      end
   endtask

   // All requesters valid with a free output: strict rotation, one grant and one result per cycle.
   task automatic test_round_robin();
      int rrExp = mRr;
      for (int c = 0; c < 12; c++) begin
         applyStimulus(4'b1111, 1'b1);
         #3;
         checks++;
         if (reqReady !== (4'b0001 << rrExp)) begin
            failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, reqReady, 4'b0001 << rrExp);
         end
         if (c >= 2) begin
            checks++;
            if (resValid !== 1'b1) begin failures++; $display("FAIL rr_streaming[%0d] got=%b exp=1", c, resValid); end
            checks++;
            if ({resId, resFlag, resData} !== mS2Item) begin
               failures++; $display("FAIL rr_result[%0d] got=%h exp=%h", c, {resId, resFlag, resData}, mS2Item);
            end
         end
         rrExp = (rrExp + 1) % 4;
         tick();
      end
   endtask

   // Downstream stall: everything holds, grants stop once S1 is full, drain preserves order.
   task automatic test_backpressure();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(4'b1111, 1'b1);
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'($urandom_range(1, 15)), 1'b0);
         #3;
         checks++;
         if (reqReady !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, reqReady); end
         checks++;
         if ({resValid, resId, resFlag, resData} !== {1'b1, mS2Item}) begin
            failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", c, resValid, {resId, resFlag, resData}, mS2Item);
         end
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         applyStimulus(4'b0000, 1'b1);
         #3;
         checks++;
         if (resValid !== mS2Valid) begin failures++; $display("FAIL bp_drain_valid[%0d] got=%b exp=%b", c, resValid, mS2Valid); end
         if (mS2Valid) begin
            checks++;
            if ({resId, resFlag, resData} !== mS2Item) begin
               failures++; $display("FAIL bp_drain_data[%0d] got=%h exp=%h", c, {resId, resFlag, resData}, mS2Item);
            end
         end
         tick();
      end
   endtask

   // Random valids, operands and downstream readiness against the model.
   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         applyStimulus(4'($urandom), ($urandom_range(0, 3) != 0));
         #3;
         checks++;
         if (reqReady !== expReady()) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, reqReady, expReady()); end
         checks++;
         if (resValid !== mS2Valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, resValid, mS2Valid); end
         if (mS2Valid) begin
            checks++;
            if ({resId, resFlag, resData} !== mS2Item) begin
               failures++; $display("FAIL rnd_result[%0d] got=%h exp=%h", c, {resId, resFlag, resData}, mS2Item);
            end
         end
         tick();
      end
`ifdef BF16_MUL_ARB_STATS_EN
      #3;
      checks++;
      if ({nanCnt, infCnt} !== {16'(mNan), 16'(mInf)}) begin
         failures++; $display("FAIL rnd_stats got=%0d/%0d exp=%0d/%0d", nanCnt, infCnt, mNan, mInf);
      end
`endif
   endtask

   // Reset with both stages full: in-flight pairs vanish and arbitration restarts at index 0.
   task automatic test_reset_midflight();
      for (int c = 0; c < 4; c++) begin
         applyStimulus(4'b1111, (c < 2));
         tick();
      end
      rst = 1'b1;
      applyStimulus(4'b1111, 1'b0);
      tick();
      rst = 1'b0;
      applyStimulus(4'b0110, 1'b1);
      #3;
      checks++;
      if (resValid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", resValid); end
      checks++;
      if (reqReady !== 4'b0010) begin failures++; $display("FAIL rst_mid_grant got=%b exp=0010", reqReady); end
`ifdef BF16_MUL_ARB_STATS_EN
      checks++;
      if ({nanCnt, infCnt} !== 32'd0) begin failures++; $display("FAIL rst_mid_stats got=%0d/%0d exp=0/0", nanCnt, infCnt); end
`endif
      tick();
      for (int c = 0; c < 4; c++) begin
         applyStimulus(4'b0000, 1'b1);
         #3;
         checks++;
         if (resValid !== mS2Valid) begin failures++; $display("FAIL rst_mid_drain[%0d] got=%b exp=%b", c, resValid, mS2Valid); end
         if (mS2Valid) begin
            checks++;
            if ({resId, resFlag, resData} !== mS2Item) begin
               failures++; $display("FAIL rst_mid_data[%0d] got=%h exp=%h", c, {resId, resFlag, resData}, mS2Item);
            end
         end
         tick();
      end
   endtask

   // Test sequence.
   initial begin
      rst      = 1'b1;
      reqValid = '0;
      reqA     = '0;
      reqB     = '0;
      resReady = 1'b1;
      test_reset();
      test_directed();
      test_round_robin();
      test_backpressure();
      test_random();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
